// File: rtl/led_bar_arbiter.sv
// Shares the 16 board LEDs between the joystick velocity bar and a handshaked
// blink-event requester, with a guard gap after each event and global PWM dimming.
module led_bar_arbiter #(
  parameter int BLINK_CYCLES = 12_500_000,
  parameter int EVT_BLINKS   = 3,
  parameter int GAP_CYCLES   = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bar_led,
  input  logic        evt_req,
  input  logic [15:0] evt_pattern,
  output logic        evt_ack,
  input  logic [3:0]  brightness,
  output logic        busy,
  output logic [15:0] led
);

  localparam logic [1:0] ST_BAR = 2'd0;
  localparam logic [1:0] ST_EVT = 2'd1;
  localparam logic [1:0] ST_GAP = 2'd2;

  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int OW = $clog2(EVT_BLINKS + 1);

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [OW-1:0] ON_LAST    = OW'(EVT_BLINKS);

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [OW-1:0] on_cnt_q, on_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          phase_q, phase_d;
  logic [15:0]   pat_q, pat_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [15:0]   led_q, led_d;
  logic [3:0]    pwm_cnt_q, pwm_cnt_d;
  logic [3:0]    bright_q, bright_d;
  logic [15:0]   source;
  logic          pwm_en;

  always_comb begin
    state_d     = state_q;
    blink_cnt_d = blink_cnt_q;
    on_cnt_d    = on_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    phase_d     = phase_q;
    pat_d       = pat_q;
    ack_d       = 1'b0;

    // brightness only moves at the period boundary so a duty cycle is never cut short
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    bright_d  = (pwm_cnt_q == 4'hF) ? brightness : bright_q;
    pwm_en    = (pwm_cnt_q <= bright_q);

    source = bar_led;
    if (state_q == ST_EVT) begin
      source = phase_q ? pat_q : 16'h0000;
    end
    led_d = pwm_en ? source : 16'h0000;

    case (state_q)
      ST_BAR: begin
        if (evt_req && !ack_q) begin
          state_d     = ST_EVT;
          pat_d       = evt_pattern;
          ack_d       = 1'b1;
          phase_d     = 1'b1;
          blink_cnt_d = '0;
          on_cnt_d    = '0;
        end
      end
      ST_EVT: begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_d = '0;
          phase_d     = !phase_q;
          if (phase_q) begin
            on_cnt_d = on_cnt_q + 1'b1;
          end else if (on_cnt_q == ON_LAST) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_BAR;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_BAR;
    endcase

    busy_d = (state_d != ST_BAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BAR;
      blink_cnt_q <= '0;
      on_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      phase_q     <= 1'b1;
      pat_q       <= 16'h0000;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      led_q       <= 16'h0000;
      pwm_cnt_q   <= 4'h0;
      bright_q    <= 4'hF;
    end else begin
      state_q     <= state_d;
      blink_cnt_q <= blink_cnt_d;
      on_cnt_q    <= on_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      phase_q     <= phase_d;
      pat_q       <= pat_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      led_q       <= led_d;
      pwm_cnt_q   <= pwm_cnt_d;
      bright_q    <= bright_d;
    end
  end

  assign evt_ack = ack_q;
  assign busy    = busy_q;
  assign led     = led_q;

endmodule

// File: tb/tb_led_bar_arbiter.sv
// Randomized bench for led_bar_arbiter: outputs are compared every cycle against
// a timeline model (event position counted in cycles, not blink/phase counters).
module tb_led_bar_arbiter;

  localparam int BLINK = 4;
  localparam int NBL   = 2;
  localparam int GAP   = 3;
  localparam int EVT_LEN = 2 * NBL * BLINK;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bar_led;
  logic        evt_req;
  logic [15:0] evt_pattern;
  logic        evt_ack;
  logic [3:0]  brightness;
  logic        busy;
  logic [15:0] led;

  int n_total = 0;
  int n_bad   = 0;

  // reference model: mode 0=bar, 1=event, 2=gap; m_t = cycles into event
  int          m_mode = 0;
  int          m_t = 0;
  int          m_g = 0;
  int          m_pwm = 0;
  int          m_bright = 15;
  logic [15:0] m_pat = 16'h0;
  logic [15:0] m_led = 16'h0;
  logic [15:0] m_src;
  logic        m_ack = 1'b0;
  logic        m_busy = 1'b0;

  led_bar_arbiter #(
    .BLINK_CYCLES(BLINK),
    .EVT_BLINKS(NBL),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bar_led(bar_led),
    .evt_req(evt_req),
    .evt_pattern(evt_pattern),
    .evt_ack(evt_ack),
    .brightness(brightness),
    .busy(busy),
    .led(led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_t = 0; m_g = 0; m_pat = 16'h0;
      m_pwm = 0; m_bright = 15;
      m_led = 16'h0; m_ack = 1'b0; m_busy = 1'b0;
    end else begin
      if (m_mode == 1)
        m_src = (((m_t / BLINK) % 2) == 0) ? m_pat : 16'h0000;
      else
        m_src = bar_led;
      m_led = (m_pwm <= m_bright) ? m_src : 16'h0000;
      if (m_pwm == 15) m_bright = int'(brightness);
      m_pwm = (m_pwm + 1) % 16;
      m_ack = 1'b0;
      case (m_mode)
        0: if (evt_req) begin
             m_mode = 1; m_t = 0; m_pat = evt_pattern; m_ack = 1'b1;
           end
        1: if (m_t == EVT_LEN - 1) begin
             m_mode = 2; m_g = 0;
           end else begin
             m_t = m_t + 1;
           end
        default: if (m_g == GAP - 1) m_mode = 0;
                 else m_g = m_g + 1;
      endcase
      m_busy = (m_mode != 0);
    end
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("led", led, m_led);
    chk("evt_ack", {15'b0, evt_ack}, {15'b0, m_ack});
    chk("busy", {15'b0, busy}, {15'b0, m_busy});
  endtask

  task automatic wait_ack(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (evt_ack) begin
        seen = 1'b1;
        break;
      end
    end
    chk("ack_timeout", {15'b0, seen}, 16'd1);
  endtask

  initial begin
    rst = 1'b1; evt_req = 1'b0; evt_pattern = 16'h0;
    bar_led = 16'h00FF; brightness = 4'hF;
    repeat (3) tick();
    rst = 1'b0;
    repeat (6) tick();

    // single event
    evt_pattern = 16'hA5A5; evt_req = 1'b1;
    wait_ack(20);
    evt_req = 1'b0;
    repeat (25) tick();

    // request held through an event and gap with a second pattern
    evt_pattern = 16'hA5A5; evt_req = 1'b1;
    wait_ack(20);
    evt_pattern = 16'h0F0F;
    wait_ack(40);
    evt_req = 1'b0;
    repeat (25) tick();

    // reset in the middle of an event with the request still held
    evt_pattern = 16'h3C3C; evt_req = 1'b1;
    wait_ack(20);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ack(20);
    evt_req = 1'b0;
    repeat (25) tick();

    // dimming, then a brightness change mid-period
    bar_led = 16'hFFFF; brightness = 4'd3;
    repeat (37) tick();
    brightness = 4'd7;
    repeat (40) tick();
    brightness = 4'hF;

    // request coinciding with reset
    rst = 1'b1; evt_req = 1'b1; evt_pattern = 16'h1234;
    tick();
    rst = 1'b0;
    wait_ack(20);
    evt_req = 1'b0;
    repeat (25) tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) bar_led = 16'($urandom);
      if ($urandom_range(0, 99) == 0) brightness = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 299) == 0);
      if (evt_req && evt_ack) begin
        evt_req = 1'b0;
      end else if (!evt_req && $urandom_range(0, 9) == 0) begin
        evt_req = 1'b1;
        evt_pattern = 16'($urandom);
      end
    end
    rst = 1'b0;
    evt_req = 1'b0;
    repeat (30) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
